// File: rtl/adc_align_pkg.sv
// adc_align_pkg: shared types and constants for the ADC frame aligner.
//   state_t        alignment FSM states
//   FRAME_PAT_DEF  default frame word when the lanes are aligned (MSB first)
//   SLIP_W/MISS_W  default counter widths for slip_cnt and miss_cnt
//   cnt_w()        width helper used by the parameterized modules
package adc_align_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    localparam int          NBITS_DEF     = 12;
    localparam int          LOSS_THR_DEF  = 3;
    localparam logic [11:0] FRAME_PAT_DEF = 12'hFC0;

    // Width able to hold 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int SLIP_W = cnt_w(NBITS_DEF);
    localparam int MISS_W = cnt_w(LOSS_THR_DEF + 1);

endpackage

// File: rtl/adc_frame_match.sv
// adc_frame_match: frame word comparator plus consecutive-miss counter.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_en          count misses (high while the aligner is locked)
//   i_clr         clear the miss counter (restart request)
//   i_frame       deserialized frame-clock word
//   o_match       i_frame equals FRAME_PAT this cycle
//   o_loss        this cycle's mismatch is the LOSS_THR-th in a row
module adc_frame_match
    import adc_align_pkg::*;
#(
    parameter int               NBITS     = NBITS_DEF,
    parameter logic [NBITS-1:0] FRAME_PAT = NBITS'(FRAME_PAT_DEF),
    parameter int               LOSS_THR  = LOSS_THR_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [NBITS-1:0] i_frame,
    output logic             o_match,
    output logic             o_loss
);

    localparam int MW = cnt_w(LOSS_THR + 1);

    logic [MW-1:0] r_miss;
    logic          w_match;

    assign w_match = (i_frame == FRAME_PAT);
    assign o_match = w_match;
    // Loss is flagged combinationally on the threshold miss so the FSM
    // leaves LOCKED on that same edge.
    assign o_loss  = i_en && !w_match && (r_miss == MW'(LOSS_THR - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || !i_en || w_match) begin
            r_miss <= '0;
        end else if (r_miss != MW'(LOSS_THR)) begin
            r_miss <= r_miss + 1'b1;
        end
    end

endmodule

// File: rtl/adc_frame_align.sv
// adc_frame_align: bitslip-based frame alignment for one octal ADC.
//   i_clk         deserialized word clock
//   i_rst         synchronous reset, active-high (priority over i_start)
//   i_start       single-cycle (re)start of alignment
//   i_frame_in    deserialized frame-clock word
//   i_data_in     NCH lanes of NBITS, lane i at [i*NBITS +: NBITS]
//   o_bitslip     one-cycle pulse to every ISERDES of this ADC
//   o_aligned     high while locked
//   o_align_err   high after NBITS-1 slips without finding the pattern
//   o_data_out    registered samples, held when not locked
//   o_data_valid  o_data_out valid this cycle
// Optional (ADC_ALIGN_STATS_EN): o_slip_total, o_lock_loss saturating
// 8-bit event counters, cleared only by reset.
module adc_frame_align
    import adc_align_pkg::*;
#(
    parameter int               NCH        = 8,
    parameter int               NBITS      = NBITS_DEF,
    parameter logic [NBITS-1:0] FRAME_PAT  = NBITS'(FRAME_PAT_DEF),
    parameter int               SETTLE_CYC = 4,
    parameter int               LOSS_THR   = LOSS_THR_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NBITS-1:0]     i_frame_in,
    input  logic [NCH*NBITS-1:0] i_data_in,
    output logic                 o_bitslip,
    output logic                 o_aligned,
    output logic                 o_align_err,
    output logic [NCH*NBITS-1:0] o_data_out,
    output logic                 o_data_valid
`ifdef ADC_ALIGN_STATS_EN
   ,output logic [7:0]           o_slip_total,
    output logic [7:0]           o_lock_loss
`endif
);

    localparam int SLIP_CW = cnt_w(NBITS);
    localparam int SET_W   = cnt_w(SETTLE_CYC);

    state_t               r_state, w_state_nxt;
    logic [SLIP_CW-1:0]   r_slip_cnt;
    logic [SET_W-1:0]     r_settle_cnt;
    logic                 r_bitslip, r_aligned, r_align_err, r_data_valid;
    logic [NCH*NBITS-1:0] r_data_out;
    logic                 w_match, w_loss;

    adc_frame_match #(
        .NBITS    (NBITS),
        .FRAME_PAT(FRAME_PAT),
        .LOSS_THR (LOSS_THR)
    ) u_match (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (r_state == S_LOCKED),
        .i_clr  (i_start),
        .i_frame(i_frame_in),
        .o_match(w_match),
        .o_loss (w_loss)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_settle_cnt == '0) w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_match)                                w_state_nxt = S_LOCKED;
                else if (r_slip_cnt == SLIP_CW'(NBITS - 1)) w_state_nxt = S_FAIL;
                else                                        w_state_nxt = S_SLIP;
            end
            S_SLIP:   w_state_nxt = S_SETTLE;
            S_LOCKED: if (w_loss) w_state_nxt = S_SETTLE;
            S_FAIL:   w_state_nxt = S_FAIL;
            default:  w_state_nxt = S_IDLE;
        endcase
        // A restart from any state wins over the per-state decision.
        if (i_start) w_state_nxt = S_SETTLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_slip_cnt   <= '0;
            r_settle_cnt <= '0;
            r_bitslip    <= 1'b0;
            r_aligned    <= 1'b0;
            r_align_err  <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Reload on every fresh entry into SETTLE, including a restart
            // requested while already settling.
            if (w_state_nxt == S_SETTLE && (r_state != S_SETTLE || i_start))
                r_settle_cnt <= SET_W'(SETTLE_CYC - 1);
            else if (r_state == S_SETTLE && r_settle_cnt != '0)
                r_settle_cnt <= r_settle_cnt - 1'b1;

            // Every path into a new alignment attempt passes through one of
            // these states, so clearing here restarts the slip count.
            if (i_start || r_state == S_IDLE || r_state == S_LOCKED || r_state == S_FAIL)
                r_slip_cnt <= '0;
            else if (r_state == S_SLIP)
                r_slip_cnt <= r_slip_cnt + 1'b1;

            // Outputs are registered from the next state so they line up
            // exactly with the state they describe.
            r_bitslip    <= (w_state_nxt == S_SLIP);
            r_aligned    <= (w_state_nxt == S_LOCKED);
            r_align_err  <= (w_state_nxt == S_FAIL);
            r_data_valid <= (w_state_nxt == S_LOCKED);

            // Loading on the CHECK->LOCKED edge too means the first valid
            // cycle already carries fresh samples.
            if (r_state == S_LOCKED || w_state_nxt == S_LOCKED)
                r_data_out <= i_data_in;
        end
    end

    assign o_bitslip    = r_bitslip;
    assign o_aligned    = r_aligned;
    assign o_align_err  = r_align_err;
    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;

`ifdef ADC_ALIGN_STATS_EN
    logic [7:0] r_slip_total, r_lock_loss;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slip_total <= '0;
            r_lock_loss  <= '0;
        end else begin
            if (w_state_nxt == S_SLIP && r_slip_total != 8'hFF)
                r_slip_total <= r_slip_total + 1'b1;
            // A restart in the same cycle is the cause of leaving LOCKED.
            if (r_state == S_LOCKED && w_loss && !i_start && r_lock_loss != 8'hFF)
                r_lock_loss <= r_lock_loss + 1'b1;
        end
    end

    assign o_slip_total = r_slip_total;
    assign o_lock_loss  = r_lock_loss;
`endif

endmodule

// File: tb/tb_adc_frame_align.sv
module tb_adc_frame_align;

    localparam int NCH = 8;
    localparam int NB  = 12;

    logic              clk = 1'b0;
    logic              rst, start;
    logic [NB-1:0]     frame_in;
    logic [NCH*NB-1:0] data_in;
    logic              bitslip, aligned, align_err, data_valid;
    logic [NCH*NB-1:0] data_out;
`ifdef ADC_ALIGN_STATS_EN
    logic [7:0]        slip_total, lock_loss;
`endif

    int n_checks = 0;
    int n_errors = 0;

    adc_frame_align #(
        .NCH(NCH), .NBITS(NB), .FRAME_PAT(12'hFC0), .SETTLE_CYC(4), .LOSS_THR(3)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_frame_in  (frame_in),
        .i_data_in   (data_in),
        .o_bitslip   (bitslip),
        .o_aligned   (aligned),
        .o_align_err (align_err),
        .o_data_out  (data_out),
        .o_data_valid(data_valid)
`ifdef ADC_ALIGN_STATS_EN
       ,.o_slip_total(slip_total),
        .o_lock_loss (lock_loss)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [NCH*NB-1:0] ramp(input int n);
        logic [NCH*NB-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) r[i*NB +: NB] = NB'(n + i);
        return r;
    endfunction

    function automatic logic [NB-1:0] rotl(input logic [NB-1:0] w);
        return {w[NB-2:0], w[NB-1]};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; frame_in = 12'hFC0; data_in = ramp(7);
        tick(); tick();
        n_checks++; if (bitslip !== 1'b0)    begin n_errors++; $display("FAIL reset_bitslip: got %b want 0", bitslip); end
        n_checks++; if (aligned !== 1'b0)    begin n_errors++; $display("FAIL reset_aligned: got %b want 0", aligned); end
        n_checks++; if (align_err !== 1'b0)  begin n_errors++; $display("FAIL reset_err: got %b want 0", align_err); end
        n_checks++; if (data_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_checks++; if (data_out !== '0)     begin n_errors++; $display("FAIL reset_data: got %h want 0", data_out); end
        rst = 1'b0;
        // No START: must stay idle with valid data blocked.
        for (int k = 0; k < 8; k++) tick();
        n_checks++; if (aligned !== 1'b0 || data_out !== '0) begin
            n_errors++; $display("FAIL idle_hold: aligned %b data %h want 0/0", aligned, data_out);
        end
    endtask

    // START at edge 0 with the pattern already present: lock at cycle 6.
    task automatic test_prealigned();
        do_reset();
        frame_in = 12'hFC0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_checks++; if (aligned !== (k >= 6)) begin n_errors++; $display("FAIL pre_aligned c%0d: got %b want %b", k, aligned, (k >= 6)); end
            n_checks++; if (data_valid !== (k >= 6)) begin n_errors++; $display("FAIL pre_valid c%0d: got %b want %b", k, data_valid, (k >= 6)); end
            n_checks++; if (bitslip !== 1'b0) begin n_errors++; $display("FAIL pre_bitslip c%0d: got %b want 0", k, bitslip); end
            tick();
        end
    endtask

    // Continues from LOCKED.
    task automatic test_datapath();
        int wait_c;
        for (int n = 0; n < 5; n++) begin
            data_in = ramp(n * 16);
            tick();
            n_checks++; if (data_out !== ramp(n * 16) || data_valid !== 1'b1) begin
                n_errors++; $display("FAIL dp_delay n%0d: got %h v%b want %h v1", n, data_out, data_valid, ramp(n * 16));
            end
        end
        // Three misses drop lock; data held constant across the drop.
        frame_in = 12'h000; data_in = ramp(100);
        tick(); tick(); tick();
        n_checks++; if (data_valid !== 1'b0 || aligned !== 1'b0) begin
            n_errors++; $display("FAIL dp_drop: valid %b aligned %b want 0/0", data_valid, aligned);
        end
        n_checks++; if (data_out !== ramp(100)) begin n_errors++; $display("FAIL dp_last: got %h want %h", data_out, ramp(100)); end
        data_in = ramp(200);
        tick(); tick();
        n_checks++; if (data_out !== ramp(100) || data_valid !== 1'b0) begin
            n_errors++; $display("FAIL dp_hold: got %h v%b want %h v0", data_out, data_valid, ramp(100));
        end
        // Auto realign: frame good again, lock 5 cycles after the drop cycle.
        frame_in = 12'hFC0;
        wait_c = 0;
        while (aligned !== 1'b1 && wait_c < 20) begin tick(); wait_c++; end
        n_checks++; if (wait_c != 3) begin n_errors++; $display("FAIL dp_relock: took %0d more cycles want 3", wait_c); end
    endtask

    task automatic test_lock_loss();
        int wait_c, slips;
        // Two misses then a match: counter clears, lock kept.
        frame_in = 12'h000;
        tick();
        n_checks++; if (aligned !== 1'b1) begin n_errors++; $display("FAIL ll_miss1: got %b want 1", aligned); end
        tick();
        n_checks++; if (aligned !== 1'b1) begin n_errors++; $display("FAIL ll_miss2: got %b want 1", aligned); end
        frame_in = 12'hFC0;
        tick(); tick();
        n_checks++; if (aligned !== 1'b1) begin n_errors++; $display("FAIL ll_keep: got %b want 1", aligned); end
        // Three in a row: drops the cycle after the third.
        frame_in = 12'h000;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (aligned !== 1'b1) begin n_errors++; $display("FAIL ll_before%0d: got %b want 1", k, aligned); end
            tick();
        end
        n_checks++; if (aligned !== 1'b0 || data_valid !== 1'b0) begin
            n_errors++; $display("FAIL ll_drop: aligned %b valid %b want 0/0", aligned, data_valid);
        end
        frame_in = 12'hFC0;
        wait_c = 0; slips = 0;
        while (aligned !== 1'b1 && wait_c < 20) begin
            tick(); wait_c++;
            if (bitslip) slips++;
        end
        n_checks++; if (wait_c != 5 || slips != 0) begin
            n_errors++; $display("FAIL ll_realign: %0d cycles %0d slips want 5/0", wait_c, slips);
        end
`ifdef ADC_ALIGN_STATS_EN
        n_checks++; if (lock_loss !== 8'd2) begin n_errors++; $display("FAIL stat_lockloss: got %0d want 2", lock_loss); end
`endif
    endtask

    // Bench ISERDES model: each BITSLIP rotates the frame word left by one.
    task automatic test_offset3();
        logic [NB-1:0] word;
        int pc[0:15];
        int pulses, first_al;
        bit err_seen;
        do_reset();
        word = 12'h1F8; pulses = 0; first_al = 0; err_seen = 0;
        frame_in = word;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (bitslip) begin
                if (pulses < 16) pc[pulses] = k;
                pulses++;
                word = rotl(word);
                frame_in = word;
            end
            if (aligned && first_al == 0) first_al = k;
            if (align_err) err_seen = 1;
            tick();
        end
        n_checks++; if (pulses != 3) begin n_errors++; $display("FAIL off3_pulses: got %0d want 3", pulses); end
        n_checks++; if (pulses >= 3 && (pc[0] != 6 || pc[1] != 12 || pc[2] != 18)) begin
            n_errors++; $display("FAIL off3_spacing: cycles %0d %0d %0d want 6 12 18", pc[0], pc[1], pc[2]);
        end
        n_checks++; if (first_al != 24) begin n_errors++; $display("FAIL off3_lock: first at %0d want 24", first_al); end
        n_checks++; if (err_seen) begin n_errors++; $display("FAIL off3_err: got 1 want 0"); end
`ifdef ADC_ALIGN_STATS_EN
        n_checks++; if (slip_total !== 8'd3) begin n_errors++; $display("FAIL stat_slip3: got %0d want 3", slip_total); end
`endif
    endtask

    task automatic test_never_match();
        int pulses, last_p, first_err;
        do_reset();
        frame_in = 12'h000; pulses = 0; last_p = 0; first_err = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            if (bitslip) begin pulses++; last_p = k; end
            if (align_err && first_err == 0) first_err = k;
            tick();
        end
        n_checks++; if (pulses != 11 || last_p != 66) begin
            n_errors++; $display("FAIL nm_pulses: %0d pulses last at %0d want 11 at 66", pulses, last_p);
        end
        n_checks++; if (first_err != 72) begin n_errors++; $display("FAIL nm_err_time: got %0d want 72", first_err); end
        n_checks++; if (align_err !== 1'b1 || aligned !== 1'b0) begin
            n_errors++; $display("FAIL nm_err_hold: err %b aligned %b want 1/0", align_err, aligned);
        end
`ifdef ADC_ALIGN_STATS_EN
        n_checks++; if (slip_total !== 8'd11) begin n_errors++; $display("FAIL stat_slip11: got %0d want 11", slip_total); end
`endif
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (align_err !== 1'b0) begin n_errors++; $display("FAIL nm_clear: got %b want 0", align_err); end
        tick(); tick(); tick(); tick();
        n_checks++; if (bitslip !== 1'b0) begin n_errors++; $display("FAIL nm_restart_check: got %b want 0", bitslip); end
        tick();
        n_checks++; if (bitslip !== 1'b1) begin n_errors++; $display("FAIL nm_restart_slip: got %b want 1", bitslip); end
    endtask

    task automatic test_reset_mid();
        int slips;
        do_reset();
        frame_in = 12'h000;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k < 6; k++) tick();
        n_checks++; if (bitslip !== 1'b1) begin n_errors++; $display("FAIL rm_in_slip: got %b want 1", bitslip); end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        n_checks++; if ({bitslip, aligned, align_err, data_valid} !== 4'b0000 || data_out !== '0) begin
            n_errors++; $display("FAIL rm_outputs: flags %b%b%b%b data %h want 0000/0", bitslip, aligned, align_err, data_valid, data_out);
        end
`ifdef ADC_ALIGN_STATS_EN
        n_checks++; if (slip_total !== 8'd0) begin n_errors++; $display("FAIL rm_stat: got %0d want 0", slip_total); end
`endif
        slips = 0;
        for (int k = 0; k < 12; k++) begin tick(); if (bitslip) slips++; end
        n_checks++; if (slips != 0) begin n_errors++; $display("FAIL rm_idle: got %0d slips want 0", slips); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; frame_in = '0; data_in = '0;
        test_reset();
        test_prealigned();
        test_datapath();
        test_lock_loss();
        test_offset3();
        test_never_match();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_frame_align.md
Name: adc_frame_align

Overview:
- Frame-alignment controller for one octal ADC.
- Sits directly downstream of the differential ADC input buffers and the per-lane ISERDES deserializers.
- Watches the deserialized frame-clock word and issues BITSLIP pulses to all ISERDES of that ADC until the frame pattern is found.
- Then forwards the aligned parallel sample words with a valid flag, and monitors for loss of lock.

Parameters:
- NCH, 8, data lanes per ADC.
- NBITS, 12, bits per sample and per deserialized frame word.
- FRAME_PAT, 12'hFC0, expected frame word when aligned (MSB first).
- SETTLE_CYC, 4, CLK cycles waited after each slip before comparing; must be >= 1.
- LOSS_THR, 3, consecutive frame mismatches in LOCKED that drop lock; must be >= 1.

Ports:
- CLK  in  1  deserialized word clock (frame rate).
- RST  in  1  synchronous reset, active-high.
- START  in  1  single-cycle request to (re)start alignment.
- FRAME_IN  in  NBITS  deserialized frame-clock word.
- DATA_IN  in  NCH*NBITS  deserialized sample words; lane i occupies bits [i*NBITS +: NBITS].
- BITSLIP  out  1  one-cycle pulse to all ISERDES of this ADC.
- ALIGNED  out  1  high while LOCKED.
- ALIGN_ERR  out  1  high in FAIL.
- DATA_OUT  out  NCH*NBITS  registered aligned samples.
- DATA_VALID  out  1  DATA_OUT is valid this cycle.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, slip_cnt=0, settle_cnt=0, miss_cnt=0; BITSLIP, ALIGNED, ALIGN_ERR, DATA_VALID all 0; DATA_OUT=0.
- States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE: hold until START=1, then go to SETTLE with slip_cnt=0.
- SETTLE: settle_cnt loads SETTLE_CYC-1 on entry and decrements each cycle. When it reaches 0, go to CHECK (SETTLE_CYC cycles in SETTLE).
- CHECK (1 cycle):
  - FRAME_IN==FRAME_PAT -> LOCKED.
  - Mismatch and slip_cnt==NBITS-1 -> FAIL.
  - Otherwise -> SLIP.
- SLIP (1 cycle): BITSLIP=1 for exactly this cycle; slip_cnt++; then SETTLE.
- BITSLIP is never high in two consecutive cycles. Minimum spacing between pulses is SETTLE_CYC+2 cycles.
- LOCKED:
  - ALIGNED=1 and DATA_VALID=1 every cycle.
  - DATA_OUT<=DATA_IN, 1-cycle latency.
  - miss_cnt increments on each FRAME_IN mismatch and clears on a match.
  - When miss_cnt reaches LOSS_THR: ALIGNED and DATA_VALID deassert next cycle; go to SETTLE with slip_cnt=0 (auto realign).
- Outside LOCKED: DATA_VALID=0 and DATA_OUT holds its last value.
- FAIL: ALIGN_ERR=1, held until START. START clears ALIGN_ERR next cycle and goes to SETTLE with slip_cnt=0.
- START in any state: restart at SETTLE with slip_cnt=0 and miss_cnt=0. ALIGNED, DATA_VALID and ALIGN_ERR clear on the next cycle. START in SLIP still lets that cycle's BITSLIP pulse complete.
- RST has priority over START.
- Timing with START sampled at edge 0: SETTLE occupies cycles 1..SETTLE_CYC, CHECK is at cycle SETTLE_CYC+1, ALIGNED first goes high at cycle SETTLE_CYC+2.
- Maximum slips before FAIL: NBITS-1.

Optional Feature:
- Macro: ADC_ALIGN_STATS_EN.
- When defined, add two outputs:
  - SLIP_TOTAL [7:0]: saturating count of BITSLIP pulses since RST.
  - LOCK_LOSS [7:0]: saturating count of LOCKED->SETTLE transitions caused by LOSS_THR.
  - Both reset to 0. They are not cleared by START.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package adc_align_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL);
  - the default FRAME_PAT constant;
  - localparam widths for slip_cnt (clog2(NBITS)) and miss_cnt (clog2(LOSS_THR+1)).
- One natural sub-module: adc_frame_match. It compares FRAME_IN against FRAME_PAT and maintains the consecutive-miss counter, giving a match flag and a loss flag.
- FSM and data register stay in the top module.

Test Plan:
- Pre-aligned: FRAME_IN=0xFC0 constant, START at cycle 0 (SETTLE_CYC=4) -> no BITSLIP; ALIGNED=1 and DATA_VALID=1 from cycle 6.
- Offset 3: bench ISERDES model rotates FRAME_IN left by one bit per BITSLIP, starting from 0xFC0 rotated by 3 -> exactly 3 BITSLIP pulses, 6 cycles apart, then ALIGNED=1; ALIGN_ERR stays 0.
- Never matching: FRAME_IN=0x000 -> 11 BITSLIP pulses, then ALIGN_ERR=1 and ALIGNED=0; a later START clears ALIGN_ERR next cycle and restarts alignment.
- Lock loss: in LOCKED, inject 2 mismatching frames then 0xFC0 -> ALIGNED stays 1; inject 3 consecutive mismatches -> ALIGNED=0 the cycle after the third, and realignment begins.
- Data path: in LOCKED, DATA_IN lane i = ramp n+i -> DATA_OUT equals DATA_IN delayed 1 cycle with DATA_VALID=1; after lock drop DATA_VALID=0 and DATA_OUT holds.
- Reset mid-operation: assert RST during the SLIP cycle with START also high -> next cycle all outputs 0 and state IDLE. With ADC_ALIGN_STATS_EN defined, SLIP_TOTAL=0 after reset.
